// File: rtl/hc4x_imem_if.sv
// Instruction-memory fetch channel between hc4x_core (master) and the program store (slave).
// The core holds imem_req while fetching; the store answers with imem_valid/imem_data.
interface hc4x_imem_if #(
    parameter int PC_W = 12
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic            imem_valid;

    modport master (output imem_req, output imem_addr, input imem_data, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_data, output imem_valid);
endinterface

// File: rtl/hc4x_core.sv
// Parametrised HC4 stack-machine core: FETCH/EXEC/HALT sequencer, DEPTH-level operand stack,
// occupancy-tracked overflow/underflow flags and a 2^RAM_AW x DW data RAM with async read.
module hc4x_core #(
    parameter int DW     = 4,
    parameter int DEPTH  = 3,
    parameter int PC_W   = 12,
    parameter int RAM_AW = 8
) (
    input  logic             clk,
    input  logic             nReset,
    hc4x_imem_if.master      imem,
    output logic [PC_W-1:0]  pc_out,
    output logic [7:0]       instruction_out,
    output logic [DW-1:0]    a_out,
    output logic             halted,
    output logic             stack_ovf,
    output logic             stack_unf
);
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_e;

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    state_e            state_q;
    logic              req_q, halted_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        instr_q;
    logic [DW-1:0]     stack_q [DEPTH];
    logic [DW-1:0]     stack_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              c_q, c_d, z_q, z_d, ovf_q, ovf_d, unf_q, unf_d;

    logic [DW-1:0]     ram [2**RAM_AW];
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr, ram_raddr, idx_addr;
    logic [DW-1:0]     ram_wdata, ram_rdata;

    logic [3:0]        opcode, n;
    logic [DW-1:0]     alu_res, push_val;
    logic              alu_wr, do_push, do_pop, jump, halt_d, need2, need3;
    logic [DEPTH*DW-1:0] stack_flat;

    assign opcode = instr_q[7:4];
    assign n      = instr_q[3:0];

    // Jump target is the stack read as one little-endian word: L0 in the low bits.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign stack_flat[gi*DW +: DW] = stack_q[gi];
    end

    assign idx_addr  = RAM_AW'({stack_q[1], stack_q[0]});
    assign ram_raddr = (opcode == 4'h9) ? idx_addr : RAM_AW'(n);
    assign ram_rdata = ram[ram_raddr];

    always_comb begin
        pc_d      = pc_q + PC_W'(1);
        stack_d   = stack_q;
        occ_d     = occ_q;
        c_d       = c_q;
        z_d       = z_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ram_we    = 1'b0;
        ram_waddr = RAM_AW'(n);
        ram_wdata = stack_q[0];
        alu_res   = '0;
        alu_wr    = 1'b0;
        push_val  = '0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        jump      = 1'b0;
        halt_d    = 1'b0;
        need2     = 1'b0;
        need3     = 1'b0;

        case (opcode)
            4'h1: begin {c_d, alu_res} = {1'b0, stack_q[0]} + {1'b0, stack_q[1]}; alu_wr = 1'b1; need2 = 1'b1; end
            4'h2: begin alu_res = stack_q[0] - stack_q[1]; c_d = (stack_q[0] >= stack_q[1]); alu_wr = 1'b1; need2 = 1'b1; end
            4'h3: begin alu_res = stack_q[0] & stack_q[1]; alu_wr = 1'b1; need2 = 1'b1; end
            4'h4: begin alu_res = stack_q[0] | stack_q[1]; alu_wr = 1'b1; need2 = 1'b1; end
            4'h5: begin alu_res = stack_q[0] ^ stack_q[1]; alu_wr = 1'b1; need2 = 1'b1; end
            4'h6: ram_we = 1'b1;
            4'h8: begin push_val = ram_rdata; do_push = 1'b1; end
            4'h9: begin alu_res = ram_rdata; alu_wr = 1'b1; need2 = 1'b1; end
            4'hA: begin push_val = DW'(n); do_push = 1'b1; end
            4'hB: begin
                if (n == 4'd0) begin
                    do_pop = 1'b1;
                end else if (n == 4'd1) begin
                    ram_we    = 1'b1;
                    ram_waddr = idx_addr;
                    ram_wdata = stack_q[2];
                    need3     = 1'b1;
                end
            end
            4'hC: jump = 1'b1;
            4'hD: jump = c_q;
            4'hE: jump = z_q;
            4'hF: halt_d = (n == 4'd1);
            default: ;
        endcase

        if (alu_wr) begin
            stack_d[0] = alu_res;
            z_d        = (alu_res == '0);
        end
        if (do_push) begin
            for (int i = DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i-1];
            stack_d[0] = push_val;
            z_d        = (push_val == '0);
            if (occ_q == OCC_MAX) ovf_d = 1'b1;
            else                  occ_d = occ_q + OCC_W'(1);
        end
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[DEPTH-1] = '0;
            if (occ_q == '0) unf_d = 1'b1;
            else             occ_d = occ_q - OCC_W'(1);
        end
        // Underflow is only reported; the operation still executes on whatever is in the stack.
        if ((need2 && occ_q < OCC_W'(2)) || (need3 && occ_q < OCC_W'(3))) unf_d = 1'b1;
        if (jump)   pc_d = stack_flat[PC_W-1:0];
        if (halt_d) pc_d = pc_q;
        if (state_q != S_EXEC) ram_we = 1'b0;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_FETCH;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
            pc_q     <= '0;
            instr_q  <= 8'hF0;
            stack_q  <= '{default: '0};
            occ_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        instr_q <= imem.imem_data;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                    end
                end
                S_EXEC: begin
                    pc_q    <= pc_d;
                    stack_q <= stack_d;
                    occ_q   <= occ_d;
                    c_q     <= c_d;
                    z_q     <= z_d;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    if (halt_d) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_HALT: ;
                default: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    // RAM contents survive reset; the write enable is already dead once reset forces FETCH.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc_out          = pc_q;
    assign instruction_out = instr_q;
    assign a_out           = stack_q[0];
    assign halted          = halted_q;
    assign stack_ovf       = ovf_q;
    assign stack_unf       = unf_q;
endmodule

// File: tb/tb_hc4x_core.sv
// Scoreboard bench for hc4x_core: the driver plays instruction memory and pushes model results,
// a negedge monitor pops them whenever the core finishes an instruction.
module tb_hc4x_core;
    localparam int DW = 4, DEPTH = 3, PC_W = 12, RAM_AW = 8;
    localparam int M = (1 << DW) - 1, PCM = 1 << PC_W, RAMN = 1 << RAM_AW;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [DW-1:0]   a;
        logic [7:0]      ins;
        logic            ovf, unf, hlt;
    } exp_t;

    logic clk = 1'b0, nReset = 1'b0;
    logic [PC_W-1:0] pc_out;
    logic [7:0]      instruction_out;
    logic [DW-1:0]   a_out;
    logic            halted, stack_ovf, stack_unf;

    hc4x_imem_if #(.PC_W(PC_W)) imem ();

    hc4x_core #(.DW(DW), .DEPTH(DEPTH), .PC_W(PC_W), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .nReset(nReset), .imem(imem),
        .pc_out(pc_out), .instruction_out(instruction_out), .a_out(a_out),
        .halted(halted), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    exp_t exp_q[$];

    // Reference model: stack as a queue (front = A), RAM as a plain array.
    int m_stk[$];
    int m_ram[RAMN];
    int m_occ, m_c, m_z, m_pc, m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_stk.delete();
        for (int i = 0; i < DEPTH; i++) m_stk.push_back(0);
        m_occ = 0; m_c = 0; m_z = 0; m_pc = 0; m_ovf = 0; m_unf = 0;
        exp_q.delete();
    endfunction

    function automatic void m_push(input int v);
        m_stk.push_front(v & M);
        void'(m_stk.pop_back());
        if (m_occ == DEPTH) m_ovf = 1; else m_occ++;
        m_z = ((v & M) == 0);
    endfunction

    function automatic void m_set_a(input int v);
        m_stk[0] = v & M;
        m_z = ((v & M) == 0);
    endfunction

    function automatic void model_step(input logic [7:0] ins);
        int op = int'(ins[7:4]);
        int n = int'(ins[3:0]);
        int a = m_stk[0], b = m_stk[1], l2 = m_stk[2];
        int idx = (b * (M + 1) + a) % RAMN;
        int tgt = 0;
        bit jump = 0, hlt = 0;
        exp_t e;
        for (int i = 0; i < DEPTH; i++) tgt += m_stk[i] * (1 << (DW * i));
        tgt = tgt % PCM;
        if (((op >= 1 && op <= 5) || op == 9) && m_occ < 2) m_unf = 1;
        if (op == 11 && n == 1 && m_occ < 3) m_unf = 1;
        case (op)
            1: begin m_c = (a + b > M); m_set_a(a + b); end
            2: begin m_c = (a >= b); m_set_a(a - b); end
            3: m_set_a(a & b);
            4: m_set_a(a | b);
            5: m_set_a(a ^ b);
            6: m_ram[n % RAMN] = a;
            8: m_push(m_ram[n % RAMN]);
            9: m_set_a(m_ram[idx]);
            10: m_push(n);
            11: begin
                if (n == 0) begin
                    void'(m_stk.pop_front());
                    m_stk.push_back(0);
                    if (m_occ == 0) m_unf = 1; else m_occ--;
                end else if (n == 1) begin
                    m_ram[idx] = l2;
                end
            end
            12: jump = 1;
            13: jump = (m_c != 0);
            14: jump = (m_z != 0);
            15: hlt = (n == 1);
            default: ;
        endcase
        if (!hlt) m_pc = jump ? tgt : (m_pc + 1) % PCM;
        e.pc = PC_W'(m_pc); e.a = DW'(m_stk[0]); e.ins = ins;
        e.ovf = (m_ovf != 0); e.unf = (m_unf != 0); e.hlt = hlt;
        exp_q.push_back(e);
    endfunction

    // Waits out `stall` idle fetch cycles, then hands one byte to the core and lets it execute.
    task automatic issue(input logic [7:0] ins, input int stall);
        int t = 0;
        for (int i = 0; i < stall; i++) begin
            imem.imem_valid = 1'b0;
            @(negedge clk);
            chk("stall_addr", 32'(imem.imem_addr), 32'(m_pc));
            chk("stall_req", 32'(imem.imem_req), 32'd1);
        end
        while (!imem.imem_req && t < 20) begin @(negedge clk); t++; end
        if (!imem.imem_req) begin
            vectors++; miscompares++;
            $display("FAIL fetch_timeout: imem_req stuck at 0 for ins %02h", ins);
            return;
        end
        imem.imem_valid = 1'b1;
        imem.imem_data  = ins;
        @(posedge clk);
        model_step(ins);
        @(negedge clk);
        imem.imem_valid = 1'($urandom_range(0, 1));
        imem.imem_data  = 8'($urandom);
        @(negedge clk);
        imem.imem_valid = 1'b0;
    endtask

    task automatic li(input int v, input int stall);
        issue(8'hA0 | 8'(v & 15), stall);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 nReset = 1'b0;
        imem.imem_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    // Monitor: an instruction has completed when the core leaves EXEC (req or halted rises).
    initial begin
        logic prev_req, prev_h;
        exp_t e;
        int tx;
        prev_req = 1'b1; prev_h = 1'b0; tx = 0;
        forever begin
            @(negedge clk);
            if (!nReset) begin
                prev_req = 1'b1; prev_h = 1'b0;
            end else begin
                if (!prev_req && !prev_h && (imem.imem_req || halted)) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_output: pc=%03h a=%0h ins=%02h", pc_out, a_out, instruction_out);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pc_out, a_out, instruction_out, stack_ovf, stack_unf, halted} !==
                            {e.pc, e.a, e.ins, e.ovf, e.unf, e.hlt}) begin
                            miscompares++;
                            $display("FAIL txn %0d ins=%02h: got pc=%03h a=%0h ins=%02h ovf=%0b unf=%0b halt=%0b expected pc=%03h a=%0h ins=%02h ovf=%0b unf=%0b halt=%0b",
                                     tx, e.ins, pc_out, a_out, instruction_out, stack_ovf, stack_unf, halted,
                                     e.pc, e.a, e.ins, e.ovf, e.unf, e.hlt);
                        end else begin
                            $display("txn %0d ins=%02h pc=%03h a=%0h ovf=%0b unf=%0b halt=%0b ok",
                                     tx, e.ins, pc_out, a_out, stack_ovf, stack_unf, halted);
                        end
                    end
                    tx++;
                end
                prev_req = imem.imem_req; prev_h = halted;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        imem.imem_valid = 1'b0;
        imem.imem_data  = 8'h00;
        model_reset();
        @(negedge clk); @(negedge clk);
        nReset = 1'b1;

        // Fill every RAM word through STX so later loads have known contents.
        for (int ad = 0; ad < RAMN; ad++) begin
            li($urandom_range(0, 15), 0);
            li(ad >> 4, 0);
            li(ad & 15, 0);
            issue(8'hB1, 0);
            issue(8'hB0, 0); issue(8'hB0, 0); issue(8'hB0, 0);
        end

        // Reset state observed while the fetch is stalled; RAM is retained.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_req", 32'(imem.imem_req), 32'd1);
            chk("rst_addr", 32'(imem.imem_addr), 32'd0);
        end
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_instr", 32'(instruction_out), 32'hF0);
        chk("rst_flags", 32'({halted, stack_ovf, stack_unf}), 32'd0);

        li(7, 1); li(9, 0); issue(8'h10, 2); issue(8'h63, 0); issue(8'h83, 1);
        issue(8'hB0, 0); issue(8'hB0, 0); issue(8'hB0, 0);
        li(5, 0); li(3, 0); issue(8'h20, 0);
        issue(8'hB0, 0); issue(8'hB0, 0);
        li(2, 0); li(2, 0); issue(8'h20, 0);
        issue(8'hB0, 0); issue(8'hB0, 0);
        li(1, 0); li(2, 0); li(3, 0); issue(8'hC0, 0);
        issue(8'hE0, 0); issue(8'hD0, 3);
        issue(8'hB0, 0); issue(8'hB0, 0); issue(8'hB0, 0);
        li(1, 0); li(2, 0); li(3, 0); li(4, 0);
        for (int i = 0; i < 5; i++) issue(8'hB0, 0);

        // Randomised programs, HALT excluded.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ins;
            ins = 8'($urandom);
            if (ins == 8'hF1) ins = 8'h00;
            issue(ins, $urandom_range(0, 2));
        end

        // Reset landing in the middle of ST must leave RAM[3] untouched.
        do_reset();
        v = (m_ram[3] + 1) & M;
        li(v, 0);
        while (!imem.imem_req) @(negedge clk);
        imem.imem_valid = 1'b1;
        imem.imem_data  = 8'h63;
        @(posedge clk);
        @(negedge clk);
        imem.imem_valid = 1'b0;
        #2 nReset = 1'b0;
        #1;
        chk("abort_pc", 32'(pc_out), 32'd0);
        chk("abort_req", 32'(imem.imem_req), 32'd1);
        model_reset();
        @(negedge clk);
        nReset = 1'b1;
        issue(8'h83, 0);

        // HALT at 0x005, then asynchronous reset during the halted stall.
        do_reset();
        for (int i = 0; i < 5; i++) issue(8'h00, 0);
        issue(8'hF1, 1);
        for (int i = 0; i < 3; i++) begin
            imem.imem_valid = 1'b1;
            imem.imem_data  = 8'hA1;
            @(negedge clk);
            chk("halt_pc", 32'(pc_out), 32'h005);
            chk("halt_req", 32'(imem.imem_req), 32'd0);
            chk("halt_flag", 32'(halted), 32'd1);
        end
        imem.imem_valid = 1'b0;
        @(negedge clk);
        #2 nReset = 1'b0;
        #1;
        chk("rst_halt_pc", 32'(pc_out), 32'd0);
        chk("rst_halt_flag", 32'(halted), 32'd0);
        model_reset();
        @(negedge clk);
        nReset = 1'b1;
        li(6, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hc4x_core.md
# hc4x_core

Parametrised successor to the HC4 stack-machine CPU core. It widens the data path, deepens the operand stack, and adds stall-capable instruction fetch, occupancy-tracked stack overflow/underflow flags, indexed RAM access and a HALT instruction. It sits between an external instruction memory (valid handshake) and an internal data RAM. Debug outputs feed the board-level probes.

## Interface
- DW, 4: data/stack word width; ≥4.
- DEPTH, 3: stack levels L0 (A), L1 (B), L2 (C), …; ≥3 and DEPTH·DW ≥ PC_W.
- PC_W, 12: program counter width.
- RAM_AW, 8: data RAM address width; RAM is 2^RAM_AW × DW.

Ports:
- clk  in  1  single clock; all state on posedge.
- nReset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address, equals pc.
- imem_data  in  8  instruction byte, sampled when imem_req && imem_valid.
- imem_valid  in  1  instruction memory has data.
- pc_out  out  PC_W  current pc.
- instruction_out  out  8  latched instruction.
- a_out  out  DW  stack level A.
- halted  out  1  core in HALT.
- stack_ovf  out  1  sticky: push while occupancy = DEPTH.
- stack_unf  out  1  sticky: pop/ALU read while occupancy is too low.

## Operation
- FSM states: FETCH, EXEC, HALT.
  - FETCH: imem_req=1. On imem_valid, latch imem_data into instr and go to EXEC. Otherwise hold all state.
  - EXEC: execute instr in one cycle, update pc, go to FETCH. HALT instruction goes to HALT instead.
  - HALT: imem_req=0, halted=1. Exits only through reset.
- Instruction format: opcode instr[7:4], operand n = instr[3:0].
- Push: L[i]←L[i-1], L0←v, deepest level discarded.
- Pop: L[i]←L[i+1], deepest level←0.
- Occupancy counter (0..DEPTH, saturating):
  - Push at DEPTH sets stack_ovf.
  - POP at 0 sets stack_unf.
  - Binary ALU op, STX or LDX with occupancy <2 sets stack_unf; STX requires <3.
  - The operation executes regardless.
- Opcodes:
  - 0x1 ADD: {C,A}←A+B.
  - 0x2 SUB: A←A−B (mod 2^DW); C←(A≥B).
  - 0x3 AND, 0x4 OR, 0x5 XOR: A←op(A,B); C unchanged.
  - 0x1–0x5 do not change occupancy; B and deeper levels unchanged.
  - 0x0, 0x7 RSV: act as NOP.
  - 0x6 ST n: RAM[zext(n)]←A; stack unchanged.
  - 0x7 is reserved (above); STX is 0xB with n=1. See below.
  - 0x8 LD n: push RAM[zext(n)].
  - 0x9 LDX: A←RAM[{B,A} truncated/zero-extended to RAM_AW]; no push.
  - 0xA LI n: push zext(n).
  - 0xB n: n=0 POP. n=1 STX: RAM[{B,A}]←L2; stack unchanged. Other n: NOP.
  - 0xC JP: pc←{L[k-1],…,L1,L0}[PC_W-1:0], with k=ceil(PC_W/DW).
  - 0xD JC: jump if C. 0xE JZ: jump if Z.
  - Jumps do not pop.
  - 0xF n: n=1 HALT; otherwise NOP.
- Flags:
  - Z←(new A==0) on 0x1–0x5, LD, LDX, LI; otherwise unchanged.
  - C changes only on ADD/SUB.
- Non-jump and not-taken instructions: pc←pc+1 mod 2^PC_W (0xFFF wraps to 0).

## Timing
- Reset (asynchronous, any state):
  - pc=0, all stack levels 0, C=Z=0, occupancy 0, ovf=unf=0.
  - instr=0xF0, state FETCH, halted=0.
  - RAM not cleared.
  - imem_req=1 from the first cycle after release.
- Minimum 2 cycles per instruction: fetch accepted at edge t, executed at edge t+1, next fetch starts at t+1.
- imem_valid low for N cycles in FETCH adds N cycles; imem_addr stays stable.
- imem_valid is ignored outside FETCH.
- RAM read is combinational within EXEC. A write in EXEC is visible to the next instruction.
- Reset asserted mid-EXEC aborts the instruction: no RAM write and no pc update.

## Test plan
- Reset, then hold imem_valid=0 for 5 cycles → pc_out=0, imem_req=1, imem_addr=0, a_out=0, all flags 0.
- DW=4: LI 7, LI 9, ADD, ST 3, LD 3 → after ADD A=0, C=1, Z=1; RAM[3]=0; after LD A=0, occupancy 3.
- LI 5, LI 3, SUB → A=0xE, C=0, Z=0. Then LI 2, LI 2, SUB → A=0, C=1, Z=1.
- LI 1, LI 2, LI 3, JP → pc=0x123. With Z=0, JZ → pc=old pc+1. With C=1, JC → jump taken.
- DEPTH=3: four LI → stack_ovf=1 on the 4th. Five POP → stack_unf=1. Both flags stay set until reset.
- Program HALT at 0x005 → halted=1, imem_req=0, pc frozen. Pulse nReset low mid-stall (imem_valid=0) → pc=0, halted=0 immediately.
